bcd_scoreboard: RTL and testbench

- Parametrised multi-player BCD score counter. Next generation of the two-digit single-player goal counter.
- Sits between the goal-detection logic and the seven-segment display driver.
- Adds N players, configurable digit count, goal edge detection, saturate/wrap mode, win detection and a game-state FSM.
- Each player's score is a packed BCD field that the display driver consumes directly.

---
 rtl/bcd_score_pkg.sv | 63 ++++++
 rtl/bcd_score_counter.sv | 45 ++++
 rtl/bcd_scoreboard.sv | 138 +++++++++++++
 tb/tb_bcd_scoreboard.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_score_pkg.sv
// Shared types and helpers for the multi-player BCD scoreboard.
//   state_e    : game-state FSM encoding (IDLE, PLAY, WON)
//   bcd_inc    : next value of a packed BCD score after one increment
//   dec_to_bcd : converts a decimal constant into packed BCD
// Helpers work on a MAX_DIGITS-wide field. Callers zero-extend narrower
// scores on the way in and truncate the result on the way out.
package bcd_score_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned MAX_W      = BCD_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2
  } state_e;

  // Ripple-carry BCD increment over the lowest 'digits' digits.
  // At all-9s the value either holds (sat=1) or wraps to zero (sat=0).
  function automatic logic [MAX_W-1:0] bcd_inc(input logic [MAX_W-1:0] value,
                                               input int unsigned      digits,
                                               input logic             sat);
    logic [MAX_W-1:0] result;
    logic             carry;
    logic             all_nines;
    logic [BCD_W-1:0] dig;
    result    = value;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
      if (d < digits) begin
        dig = value[d*BCD_W +: BCD_W];
        if (dig != 4'd9) all_nines = 1'b0;
        if (carry) begin
          if (dig == 4'd9) begin
            result[d*BCD_W +: BCD_W] = '0;
          end else begin
            result[d*BCD_W +: BCD_W] = dig + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    // The ripple already yields zero at all-9s, so only saturation needs
    // an explicit override.
    if (all_nines && sat) result = value;
    return result;
  endfunction

  function automatic logic [MAX_W-1:0] dec_to_bcd(input int unsigned v);
    logic [MAX_W-1:0] result;
    int unsigned      rem;
    result = '0;
    rem    = v;
    for (int unsigned d = 0; d < MAX_DIGITS; d++) begin
      result[d*BCD_W +: BCD_W] = 4'(rem % 10);
      rem = rem / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// One player's packed-BCD score register.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : add one to the score this cycle
//   sat        : 1 = hold at all-9s, 0 = wrap to zero
//   value      : current score, least-significant digit in the lowest bits
//   at_max     : current score is all-9s
module bcd_counter
  import bcd_score_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    inc,
  input  logic                    sat,
  output logic [DIGITS*BCD_W-1:0] value,
  output logic                    at_max
);

  localparam int unsigned W = DIGITS * BCD_W;

  logic [W-1:0] value_q, value_d;

  always_comb begin
    // NOTE: default first so every path assigns value_d and no latch is inferred.
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = W'(bcd_inc(MAX_W'(value_q), DIGITS, sat));
    end
  end

  // NOTE: non-blocking assignment for state, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value  = value_q;
  assign at_max = (value_q == {DIGITS{4'h9}});

endmodule

// File: rtl/bcd_scoreboard.sv
// Multi-player BCD scoreboard with goal edge detection, a game-state FSM
// and win detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : game enable; low forces IDLE and zero scores
//   clear      : one-cycle pulse that zeroes all scores and restarts play
//   goal       : per-player goal strobe (bit i = player i)
//   scores     : packed BCD, player i at [i*DIGITS*4 +: DIGITS*4]
//   winner     : players that reached WIN_SCORE, latched on entering WON
//   game_over  : high while in WON
//   at_max     : per-player score is all-9s
module bcd_scoreboard
  import bcd_score_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned WIN_SCORE   = 15,
  parameter int unsigned SATURATE    = 1,
  parameter int unsigned EDGE_DETECT = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                clear,
  input  logic [NUM_PLAYERS-1:0]              goal,
  output logic [NUM_PLAYERS*DIGITS*BCD_W-1:0] scores,
  output logic [NUM_PLAYERS-1:0]              winner,
  output logic                                game_over,
  output logic [NUM_PLAYERS-1:0]              at_max
);

  localparam int unsigned      SCORE_W = DIGITS * BCD_W;
  localparam logic [MAX_W-1:0] WIN_BCD = dec_to_bcd(WIN_SCORE);
  localparam logic             WIN_EN  = (WIN_SCORE != 0);
  localparam logic             SAT     = (SATURATE != 0);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_chk_players
    $error("NUM_PLAYERS must be 1..8");
  end
  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_chk_digits
    $error("DIGITS must be 1..4");
  end
  if (WIN_SCORE >= 10 ** DIGITS) begin : g_chk_win
    $error("WIN_SCORE does not fit in DIGITS BCD digits");
  end

  state_e                   state_q, state_d;
  logic [NUM_PLAYERS-1:0]   goal_q;
  logic [NUM_PLAYERS-1:0]   inc;
  logic [NUM_PLAYERS-1:0]   take_inc;
  logic [NUM_PLAYERS-1:0]   win_hit;
  logic [NUM_PLAYERS-1:0]   winner_q, winner_d;
  logic                     clr_scores;
  logic [SCORE_W-1:0]       score [NUM_PLAYERS];

  // Goal history is kept in every state, so a goal already held high when
  // PLAY starts is not counted as a fresh edge.
  if (EDGE_DETECT != 0) begin : g_edge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) goal_q <= '0;
      else        goal_q <= goal;
    end
  end else begin : g_level
    assign goal_q = '0;
  end

  assign inc = goal & ~goal_q;

  // Priority: enable low beats clear, clear beats goal.
  assign take_inc   = (enable && !clear && state_q == PLAY) ? inc : '0;
  assign clr_scores = !enable || clear || (state_q == IDLE);

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    bcd_counter #(.DIGITS(DIGITS)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr_scores),
      .inc    (take_inc[i]),
      .sat    (SAT),
      .value  (score[i]),
      .at_max (at_max[i])
    );
    assign scores[i*SCORE_W +: SCORE_W] = score[i];

    // Win is judged on the incremented value, so game_over rises on the
    // same edge that the winning score appears.
    assign win_hit[i] = WIN_EN && take_inc[i] &&
      (SCORE_W'(bcd_inc(MAX_W'(score[i]), DIGITS, SAT)) == WIN_BCD[SCORE_W-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    unique case (state_q)
      IDLE: begin
        winner_d = '0;
        if (enable) state_d = PLAY;
      end
      PLAY: begin
        if (!enable) begin
          state_d  = IDLE;
          winner_d = '0;
        end else if (|win_hit) begin
          state_d  = WON;
          winner_d = win_hit;
        end
      end
      WON: begin
        if (!enable) begin
          state_d  = IDLE;
          winner_d = '0;
        end else if (clear) begin
          state_d  = PLAY;
          winner_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        winner_d = '0;
      end
    endcase
  end

  always_comb begin
    game_over = (state_q == WON);
    winner    = winner_q;
  end

endmodule

// File: tb/tb_bcd_scoreboard.sv
// Self-checking bench for bcd_scoreboard. Four instances with different
// parameter sets share one stimulus stream; each phase checks the
// instance whose behaviour it targets.
module tb_bcd_scoreboard;

  typedef struct {
    logic [15:0] scores;
    logic [1:0]  winner;
    logic        game_over;
  } exp_t;

  typedef struct {
    logic       en;
    logic       clr;
    logic [1:0] g;
    exp_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] goal = 2'b00;

  logic [15:0] m_scores, l_scores, s_scores, w_scores;
  logic [1:0]  m_winner, l_winner, s_winner, w_winner;
  logic        m_go, l_go, s_go, w_go;
  logic [1:0]  m_at_max, l_at_max, s_at_max, w_at_max;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  vec_t vecs[17];

  always #5 clk = ~clk;

  bcd_scoreboard #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(15), .SATURATE(1), .EDGE_DETECT(1)) u_main (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .goal(goal),
    .scores(m_scores), .winner(m_winner), .game_over(m_go), .at_max(m_at_max));

  bcd_scoreboard #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0), .SATURATE(1), .EDGE_DETECT(0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .goal(goal),
    .scores(l_scores), .winner(l_winner), .game_over(l_go), .at_max(l_at_max));

  bcd_scoreboard #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0), .SATURATE(1), .EDGE_DETECT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .goal(goal),
    .scores(s_scores), .winner(s_winner), .game_over(s_go), .at_max(s_at_max));

  bcd_scoreboard #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0), .SATURATE(0), .EDGE_DETECT(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .goal(goal),
    .scores(w_scores), .winner(w_winner), .game_over(w_go), .at_max(w_at_max));

  function automatic logic [7:0] bcd2(input int k);
    return {4'((k / 10) % 10), 4'(k % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the
  // rising edge that consumes them.
  task automatic drive(input logic en, input logic clr, input logic [1:0] g);
    @(negedge clk);
    enable = en;
    clear  = clr;
    goal   = g;
    @(posedge clk);
    #1;
  endtask

  task automatic compare_main(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: got empty scoreboard, expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " scores"},    32'(m_scores), 32'(e.scores));
      check({tag, " winner"},    32'(m_winner), 32'(e.winner));
      check({tag, " game_over"}, 32'(m_go),     32'(e.game_over));
    end
  endtask

  task automatic step_main(input string tag, input logic en, input logic clr, input logic [1:0] g,
                           input logic [15:0] s, input logic [1:0] w, input logic go);
    exp_t e;
    e.scores    = s;
    e.winner    = w;
    e.game_over = go;
    exp_q.push_back(e);
    drive(en, clr, g);
    compare_main(tag);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    clear  = 1'b0;
    goal   = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Edge-detect main instance, one cycle per row, starting from reset.
    vecs[0]  = '{1'b1, 1'b0, 2'b00, '{16'h0000, 2'b00, 1'b0}}; // IDLE -> PLAY
    vecs[1]  = '{1'b1, 1'b0, 2'b01, '{16'h0001, 2'b00, 1'b0}};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, '{16'h0001, 2'b00, 1'b0}}; // held, no edge
    vecs[3]  = '{1'b1, 1'b0, 2'b00, '{16'h0001, 2'b00, 1'b0}};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, '{16'h0101, 2'b00, 1'b0}};
    vecs[5]  = '{1'b1, 1'b0, 2'b11, '{16'h0102, 2'b00, 1'b0}}; // only bit 0 rises
    vecs[6]  = '{1'b1, 1'b0, 2'b00, '{16'h0102, 2'b00, 1'b0}};
    vecs[7]  = '{1'b1, 1'b0, 2'b11, '{16'h0203, 2'b00, 1'b0}};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, '{16'h0203, 2'b00, 1'b0}};
    vecs[9]  = '{1'b1, 1'b1, 2'b01, '{16'h0000, 2'b00, 1'b0}}; // clear drops goal
    vecs[10] = '{1'b1, 1'b0, 2'b00, '{16'h0000, 2'b00, 1'b0}};
    vecs[11] = '{1'b1, 1'b0, 2'b01, '{16'h0001, 2'b00, 1'b0}};
    vecs[12] = '{1'b0, 1'b0, 2'b00, '{16'h0000, 2'b00, 1'b0}}; // enable drop
    vecs[13] = '{1'b0, 1'b0, 2'b01, '{16'h0000, 2'b00, 1'b0}}; // IDLE ignores goal
    vecs[14] = '{1'b1, 1'b0, 2'b01, '{16'h0000, 2'b00, 1'b0}}; // IDLE -> PLAY
    vecs[15] = '{1'b1, 1'b0, 2'b00, '{16'h0000, 2'b00, 1'b0}};
    vecs[16] = '{1'b1, 1'b0, 2'b01, '{16'h0001, 2'b00, 1'b0}}; // resumes from 0

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset scores",    32'(m_scores), 32'h0);
    check("reset winner",    32'(m_winner), 32'h0);
    check("reset game_over", 32'(m_go),     32'h0);
    check("reset at_max",    32'(m_at_max), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step_main($sformatf("vec[%0d]", i), vecs[i].en, vecs[i].clr, vecs[i].g,
                vecs[i].exp.scores, vecs[i].exp.winner, vecs[i].exp.game_over);
    end

    // Twelve one-cycle pulses on player 0, gap of two cycles.
    do_reset();
    step_main("pulse enter", 1'b1, 1'b0, 2'b00, 16'h0000, 2'b00, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step_main($sformatf("pulse %0d", k), 1'b1, 1'b0, 2'b01, {8'h00, bcd2(k)}, 2'b00, 1'b0);
      repeat (2) step_main($sformatf("pulse gap %0d", k), 1'b1, 1'b0, 2'b00, {8'h00, bcd2(k)}, 2'b00, 1'b0);
    end

    // Held goal: one edge in edge mode, one count per cycle in level mode.
    do_reset();
    drive(1'b1, 1'b0, 2'b00);
    repeat (5) drive(1'b1, 1'b0, 2'b10);
    check("held edge p1",  32'(m_scores[15:8]), 32'h01);
    check("held edge p0",  32'(m_scores[7:0]),  32'h00);
    check("held level p1", 32'(l_scores[15:8]), 32'h05);

    // Tie win at 15, frozen scores, then clear with a simultaneous goal.
    do_reset();
    step_main("tie enter", 1'b1, 1'b0, 2'b00, 16'h0000, 2'b00, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      step_main($sformatf("tie %0d", k), 1'b1, 1'b0, 2'b11, {bcd2(k), bcd2(k)},
                (k == 15) ? 2'b11 : 2'b00, k == 15);
      step_main($sformatf("tie gap %0d", k), 1'b1, 1'b0, 2'b00, {bcd2(k), bcd2(k)},
                (k == 15) ? 2'b11 : 2'b00, k == 15);
    end
    step_main("won goal ignored", 1'b1, 1'b0, 2'b11, 16'h1515, 2'b11, 1'b1);
    step_main("won idle",         1'b1, 1'b0, 2'b00, 16'h1515, 2'b11, 1'b1);
    step_main("won clear+goal",   1'b1, 1'b1, 2'b01, 16'h0000, 2'b00, 1'b0);
    step_main("after clear",      1'b1, 1'b0, 2'b00, 16'h0000, 2'b00, 1'b0);
    step_main("play after clear", 1'b1, 1'b0, 2'b01, 16'h0001, 2'b00, 1'b0);

    // Overflow at 99 with win detection disabled: saturate vs wrap.
    do_reset();
    drive(1'b1, 1'b0, 2'b00);
    for (int k = 1; k <= 99; k++) begin
      drive(1'b1, 1'b0, 2'b01);
      if (k == 9 || k == 10) check($sformatf("wrap ripple %0d", k), 32'(w_scores[7:0]), 32'(bcd2(k)));
      drive(1'b1, 1'b0, 2'b00);
    end
    check("sat at 99",         32'(s_scores[7:0]), 32'h99);
    check("sat at_max at 99",  32'(s_at_max),      32'h1);
    check("wrap at 99",        32'(w_scores[7:0]), 32'h99);
    check("wrap at_max at 99", 32'(w_at_max),      32'h1);
    drive(1'b1, 1'b0, 2'b01);
    check("sat hold",          32'(s_scores[7:0]), 32'h99);
    check("sat at_max hold",   32'(s_at_max),      32'h1);
    check("sat no game_over",  32'(s_go),          32'h0);
    check("sat no winner",     32'(s_winner),      32'h0);
    check("wrap to 00",        32'(w_scores[7:0]), 32'h00);
    check("wrap at_max clear", 32'(w_at_max),      32'h0);

    // Asynchronous reset between edges while counting.
    do_reset();
    drive(1'b1, 1'b0, 2'b00);
    repeat (7) begin
      drive(1'b1, 1'b0, 2'b01);
      drive(1'b1, 1'b0, 2'b00);
    end
    check("pre-reset count", 32'(m_scores), 32'h0007);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset scores", 32'(m_scores), 32'h0);
    check("async reset state",  32'(m_go),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
